// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths and the fetch-queue entry type.
package cpu_pkg;
  localparam int CPU_XLEN    = 32;
  localparam int CPU_INST_W  = 32;
  localparam int CPU_IADDR_W = 8;
  typedef struct packed {
    logic [CPU_INST_W-1:0] inst;
    logic [CPU_XLEN-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries; pointers carry an extra wrap bit.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d  = flush ? '0 : wr_q + {{AW{1'b0}}, push};
    rd_d  = flush ? '0 : rd_q + {{AW{1'b0}}, pop};
    count = wr_q - rd_q;
    valid = count != '0;
    head  = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/sram_1p.sv
// sram_1p: single-port word SRAM, registered read, write has priority over read.
module sram_1p #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    else rdata <= mem_q[addr];
  end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetcher with 1-cycle SRAM, credit-based prefetch queue and redirect flush.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int XLEN     = CPU_XLEN,
  parameter int INST_W   = CPU_INST_W,
  parameter int IADDR_W  = CPU_IADDR_W,
  parameter int FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_wr,
  input  logic [IADDR_W-1:0]          ld_addr,
  input  logic [INST_W-1:0]           ld_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INST_W-1:0]           out_inst,
  output logic [XLEN-1:0]             out_pc,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = FQ_DEPTH[CW:0];
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic resp_pending_q, resp_pending_d;
  logic [CW:0] occ;
  logic [INST_W-1:0] rdata;
  logic [IADDR_W-1:0] sram_addr;
  logic issue, push, pop;
  fetch_entry_t push_entry, head;
  always_comb begin
    occ            = {1'b0, fq_count} + {{CW{1'b0}}, resp_pending_q};
    issue          = !rst && !ld_wr && !redirect_valid && occ < DEPTH_L;
    fetch_pc_d     = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                   : issue ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    resp_pending_d = issue;
    resp_pc_d      = issue ? fetch_pc_q : resp_pc_q;
    push           = resp_pending_q && !redirect_valid;
    pop            = out_valid && out_ready;
    sram_addr      = ld_wr ? ld_addr : fetch_pc_q[IADDR_W+1:2];
    push_entry     = '{inst: rdata, pc: resp_pc_q};
    out_inst       = out_valid ? head.inst : '0;
    out_pc         = out_valid ? head.pc : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      resp_pc_q      <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      resp_pc_q      <= resp_pc_d;
      resp_pending_q <= resp_pending_d;
    end
  end
  sram_1p #(.AW(IADDR_W), .DW(INST_W)) u_sram (
    .clk   (clk),
    .we    (ld_wr),
    .addr  (sram_addr),
    .wdata (ld_data),
    .rdata (rdata)
  );
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .valid     (out_valid),
    .count     (fq_count)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios plus random traffic checked against a queue-level model.
module tb_ifetch_queue;
  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  logic clk = 0, rst, ld_wr, redirect_valid, out_ready, out_valid;
  logic [7:0] ld_addr;
  logic [31:0] ld_data, redirect_pc, out_inst, out_pc;
  logic [2:0] fq_count;
  int errors = 0, checks = 0;
  logic [31:0] mem_m [256];
  ent_t q_m[$];
  ent_t pend_e;
  bit pend_m, last_rst;
  logic [31:0] fpc_m;

  ifetch_queue dut (
    .clk(clk), .rst(rst), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit lw, input logic [7:0] la, input logic [31:0] ld,
                      input bit rv, input logic [31:0] rp, input bit rd);
    int cnt;
    bit issue;
    rst = r; ld_wr = lw; ld_addr = la; ld_data = ld;
    redirect_valid = rv; redirect_pc = rp; out_ready = rd;
    cnt = q_m.size();
    issue = !r && !lw && !rv && (cnt + int'(pend_m) < 4);
    if (r) begin
      q_m.delete(); pend_m = 0; fpc_m = 0;
    end else if (rv) begin
      q_m.delete(); pend_m = 0; fpc_m = rp & ~32'h3;
    end else begin
      if (cnt > 0 && rd) void'(q_m.pop_front());
      if (pend_m) q_m.push_back(pend_e);
      pend_m = issue;
      if (issue) begin
        pend_e = '{inst: mem_m[fpc_m[9:2]], pc: fpc_m};
        fpc_m += 4;
      end
    end
    if (lw) mem_m[la] = ld;
    last_rst = r;
    @(posedge clk); #1;
    chk("valid", {31'b0, out_valid}, {31'b0, q_m.size() != 0});
    chk("count", {29'b0, fq_count}, q_m.size());
    if (q_m.size() != 0) begin
      chk("inst", out_inst, q_m[0].inst);
      chk("pc", out_pc, q_m[0].pc);
    end else if (last_rst) begin
      chk("rst_inst", out_inst, 0);
      chk("rst_pc", out_pc, 0);
    end
  endtask

  task automatic run(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) step(1, 1, 8'(i), 32'h100 + i, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    // first fetch after reset: valid two cycles later, streaming one per cycle
    step(0, 0, 0, 0, 0, 0, 1);
    chk("boot_valid0", {31'b0, out_valid}, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("boot_pc0", out_pc, 0);
    chk("boot_inst0", out_inst, 32'h100);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("boot_inst1", out_inst, 32'h101);
    run(4, 1);
    // backpressure saturates at four entries
    step(1, 0, 0, 0, 0, 0, 0);
    run(8, 0);
    chk("sat_count", {29'b0, fq_count}, 4);
    chk("sat_inst", out_inst, 32'h100);
    run(10, 1);
    // redirect to 0x1E while a response is pending
    step(0, 0, 0, 0, 1, 32'h1E, 1);
    chk("rd_flush_v", {31'b0, out_valid}, 0);
    chk("rd_flush_c", {29'b0, fq_count}, 0);
    run(2, 1);
    chk("rd_pc", out_pc, 32'h1C);
    chk("rd_inst", out_inst, 32'h107);
    // back-to-back redirects
    step(0, 0, 0, 0, 1, 32'h10, 1);
    step(0, 0, 0, 0, 1, 32'h20, 1);
    run(2, 1);
    chk("b2b_pc", out_pc, 32'h20);
    chk("b2b_inst", out_inst, 32'h108);
    // program load during streaming
    for (int i = 0; i < 3; i++) step(0, 1, 8'(i), 32'hABC0 + i, 0, 0, 1);
    run(10, 1);
    step(0, 0, 0, 0, 1, 32'h0, 1);
    run(2, 1);
    chk("ld_inst", out_inst, 32'hABC0);
    // index wrap at 0x3FC
    step(0, 0, 0, 0, 1, 32'h3FC, 1);
    run(2, 1);
    chk("wrap_pc0", out_pc, 32'h3FC);
    chk("wrap_inst0", out_inst, 32'h1FF);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_pc1", out_pc, 32'h400);
    chk("wrap_inst1", out_inst, 32'hABC0);
    run(300, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(29) == 0, 8'($urandom), $urandom,
           $urandom_range(24) == 0, $urandom, $urandom_range(3) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters: XLEN=32, PC width; INST_W=32, instruction width; IADDR_W=8, instruction-memory word-address width; FQ_DEPTH=4, prefetch-queue entries (power of two, >=2); RESET_PC=0, PC after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ld_wr  in  1  program-load write strobe into instruction SRAM.
REQ-005 ld_addr  in  IADDR_W  program-load word address.
REQ-006 ld_data  in  INST_W  program-load data.
REQ-007 redirect_valid  in  1  taken branch/call/ret; flush queue and refetch.
REQ-008 redirect_pc  in  XLEN  byte target of redirect.
REQ-009 out_valid  out  1  queue head holds a valid instruction.
REQ-010 out_ready  in  1  decode accepts head this cycle.
REQ-011 out_inst  out  INST_W  head instruction.
REQ-012 out_pc  out  XLEN  byte PC of head instruction.
REQ-013 fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy.

Function
REQ-014 Fetch PC register fetch_pc; SRAM read address = fetch_pc[IADDR_W+1:2]; memory index wraps modulo 2^IADDR_W.
REQ-015 Issue a fetch in cycle c iff !rst, !ld_wr, !redirect_valid, and fq_count + resp_pending < FQ_DEPTH; on issue fetch_pc <= fetch_pc+4 (XLEN wrap) and resp_pending <= 1.
REQ-016 SRAM read latency is exactly 1 cycle: data for issue in cycle c is written into the queue, with its PC, at the end of cycle c+1; out_valid rises in cycle c+2 if the queue was empty.
REQ-017 Handshake: pop occurs iff out_valid && out_ready; out_inst/out_pc stay stable while out_valid && !out_ready.
REQ-018 Push and pop in the same cycle are both honoured; fq_count unchanged.
REQ-019 Credit rule (REQ-015) guarantees no push when full; a pop while empty cannot occur.
REQ-020 Redirect in cycle t: queue flushed (fq_count=0, out_valid=0 in t+1), a response pending in t is discarded in t+1, fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}, pop in t is ignored.
REQ-021 Redirect latency: first redirected instruction is issued in t+1 and has out_valid in t+3.
REQ-022 Back-to-back redirects: each one overrides the previous; only the last target is fetched.
REQ-023 ld_wr in a cycle writes ld_data to ld_addr and blocks issue in that cycle; a response already pending still completes; ld_wr together with redirect_valid applies both.
REQ-024 With out_ready held high and no redirect/ld_wr, steady-state throughput is one instruction per cycle.

Reset
REQ-025 While rst is high: fetch_pc=RESET_PC, queue empty, fq_count=0, resp_pending=0, out_valid=0, out_inst=0, out_pc=0; no fetch is issued.
REQ-026 rst asserted mid-operation discards queue contents and the pending response next cycle; SRAM contents are preserved.
REQ-027 First fetch from RESET_PC is issued in the first cycle with rst low, and out_valid rises 2 cycles later.

Structure
REQ-028 XLEN, INST_W, IADDR_W defaults, and a fetch-entry struct {inst, pc} live in cpu_pkg.
REQ-029 Instruction storage is the existing sram_1p instance; ld_wr muxes its address and write enable.
REQ-030 The queue is one sub-module, fetch_queue: a synchronous FIFO of FQ_DEPTH entries with push, pop, flush, count, and pointer wrap via extra MSB.

Verification
REQ-031 Load words 0..7 = 0x100..0x107 and release reset with out_ready=1 -> out_valid at cycle 2, then out_pc 0,4,8,... with out_inst 0x100,0x101,... every cycle.
REQ-032 Hold out_ready=0 after reset -> fq_count saturates at 4, with no 5th fetch issued; raise out_ready -> 0x100..0x103 in order, then streaming resumes with no gap or duplicate.
REQ-033 Redirect to 0x1E while a response is pending -> stale instruction never appears; next out_pc=0x1C 3 cycles later.
REQ-034 Redirect on consecutive cycles to 0x10 then 0x20 -> only out_pc 0x20 onward is seen.
REQ-035 Assert ld_wr for 3 cycles during streaming -> 3-cycle bubble; order and PCs remain correct; rewritten word is read on the next wrap.
REQ-036 With fetch_pc at 0x3FC and IADDR_W=8 -> the next fetch reads index 0 with out_pc 0x400.
